mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single SRAM-like memory port between the instruction-fetch requester (IF, read-only) and the data requester (MEM stage, read/write). Only one transaction is outstanding at a time. Data has priority, with a starvation guard for fetch. Fetch responses can be cancelled on a pipeline flush. Sits between the IF/MEM stages and the AXI bridge. IF and MEM derive their pause requests to the pipeline controller from the addr_ok/data_ok returned here.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, maximum consecutive data grants while fetch is pending; next grant is forced to fetch

Ports:
clk  in  1  clock
rst  in  1  reset
inst_req  in  1  fetch request; held stable until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_cancel  in  1  flush; drop the in-flight fetch response
inst_addr_ok  out  1  fetch request accepted by memory
inst_data_ok  out  1  fetch data valid
inst_rdata  out  DATA_W  fetch data
data_req  in  1  data request; held stable until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  DATA_W/8  byte enables
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  read data valid, or write complete
data_rdata  out  DATA_W  read data
mem_req  out  1  downstream request
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/DATA_W/8/ADDR_W/DATA_W  downstream command, registered
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream response
mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset rst, synchronous, active-high.
- Reset state: IDLE, starve_cnt = 0, cancel_flag = 0, all mem_* command registers = 0. Every ok output is 0.
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- IDLE, grant selection:
  - data_req && !(inst_req && starve_cnt == STARVE_MAX) -> latch the data command, go to D_ADDR.
  - else inst_req -> latch {wr=0, size=2, wstrb=0, addr=inst_addr, wdata=0}, go to I_ADDR.
  - Grant takes one cycle; no downstream request is issued in IDLE.
- starve_cnt update, at grant:
  - data granted while inst_req = 1 -> increment, saturating at STARVE_MAX.
  - fetch granted -> clear to 0.
  - data granted while inst_req = 0 -> clear to 0.
- I_ADDR / D_ADDR: mem_req = 1 with the latched command.
  - On mem_addr_ok: pulse the owner's *_addr_ok for that same cycle, go to I_DATA / D_DATA.
- I_DATA / D_DATA: mem_req = 0. On mem_data_ok, return to IDLE next cycle. Minimum transaction is 3 cycles (grant, addr, data) when addr_ok and data_ok each arrive in their first eligible cycle.
- Response routing:
  - inst_data_ok = (state == I_DATA) && mem_data_ok && !(cancel_flag || inst_cancel).
  - data_data_ok = (state == D_DATA) && mem_data_ok.
  - *_rdata = mem_rdata, combinational passthrough.
- Cancel:
  - inst_cancel in I_ADDR or I_DATA sets cancel_flag.
  - The request still completes downstream; its data_ok is swallowed; cancel_flag clears on that mem_data_ok.
  - inst_cancel in IDLE or in data states: no effect.
  - inst_cancel does not withdraw a pending inst_req; IF drops inst_req itself.
- Stray responses: mem_addr_ok outside *_ADDR and mem_data_ok outside *_DATA are ignored.
- Upstream obligation: a requester that deasserts *_req before its *_addr_ok is a protocol violation. The latched copy is still issued downstream.
- Reset mid-transaction: returns to IDLE immediately and the transaction is abandoned. The downstream bridge is reset by the same rst.
- IDLE with no requests: stays in IDLE, mem_req = 0.

Decomposition:
- Shared package (define file): state encodings ARB_IDLE..ARB_D_DATA, size codes SIZE_B/H/W.
- One sub-module: arb_grant_sel, the combinational priority and starvation decision, which is the unit-testable core.
- starve_cnt width is $clog2(STARVE_MAX+1).

Test Plan:
- Fetch only, inst_addr = 0x1C000000, memory answers with zero wait: mem_req at cycle 1 with addr 0x1C000000, size 2; inst_addr_ok at cycle 1; inst_data_ok with rdata 0x02800000 at cycle 2.
- Simultaneous inst_req and data_req (write 0xDEADBEEF, wstrb 0xF, addr 0x100): data is granted first, with mem_wr = 1. Fetch is issued only after data_data_ok.
- Data_req held continuously with inst_req pending, STARVE_MAX = 4: exactly 4 data grants, then a fetch grant, then starve_cnt = 0.
- inst_cancel pulsed in I_DATA with mem_data_ok delayed 3 cycles: inst_data_ok stays 0. The next fetch returns data normally.
- inst_cancel asserted in the same cycle as mem_data_ok: response suppressed, cancel_flag = 0 afterwards.
- rst asserted in D_DATA: next cycle state = IDLE, mem_req = 0, data_data_ok = 0. A late mem_data_ok is ignored.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the fetch/data memory-port arbiter.
//   arb_state_e : arbiter FSM state encoding (also exported on the debug port)
//   SIZE_B/H/W  : downstream transfer size codes (byte, half, word)
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_ADDR = 3'd1,
    ARB_I_DATA = 3'd2,
    ARB_D_ADDR = 3'd3,
    ARB_D_DATA = 3'd4
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_arb_grant_sel.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_arb_grant_sel
// Combinational grant decision for the memory-port arbiter. Data wins unless
// fetch has been passed over STARVE_MAX times in a row while pending; in that
// case fetch is forced. Also produces the next starvation count.
// Ports:
//   inst_req_i        fetch request pending
//   data_req_i        data request pending
//   starve_cnt_i      consecutive data grants while fetch was pending
//   grant_data_o      data is granted this cycle
//   grant_inst_o      fetch is granted this cycle
//   starve_cnt_d_o    starvation count after this decision
// -----------------------------------------------------------------------------
module mem_bus_arbiter_arb_grant_sel #(
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             inst_req_i,
  input  logic             data_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             grant_data_o,
  output logic             grant_inst_o,
  output logic [CNT_W-1:0] starve_cnt_d_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic force_inst;

  always_comb begin
    force_inst     = inst_req_i && (starve_cnt_i == STARVE_LIM);
    grant_data_o   = data_req_i && !force_inst;
    grant_inst_o   = inst_req_i && !grant_data_o;
    starve_cnt_d_o = starve_cnt_i;
    if (grant_data_o) begin
      // Only count grants that actually made fetch wait.
      if (inst_req_i) begin
        if (starve_cnt_i != STARVE_LIM) begin
          starve_cnt_d_o = starve_cnt_i + CNT_W'(1);
        end
      end else begin
        starve_cnt_d_o = '0;
      end
    end else if (grant_inst_o) begin
      starve_cnt_d_o = '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-like memory port between instruction fetch (read-only) and
// the data requester (read/write). One transaction outstanding at a time; data
// has priority with a starvation guard for fetch; an in-flight fetch response
// can be cancelled on a pipeline flush.
//
// Handshake: a requester raises *_req with a stable command and holds it until
// the cycle in which *_addr_ok is 1 (that cycle is the accept). The response
// is a single-cycle *_data_ok pulse with *_rdata valid in the same cycle.
// Downstream uses the same scheme: mem_req with a stable command is held until
// mem_addr_ok; mem_data_ok marks the response. There is no back-pressure on
// responses.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request and address
//   inst_cancel                   flush: swallow the in-flight fetch response
//   inst_addr_ok/data_ok/rdata    fetch accept, response strobe, data
//   data_req/wr/size/wstrb/addr/wdata  data request and command
//   data_addr_ok/data_ok/rdata    data accept, response strobe, data
//   mem_req/wr/size/wstrb/addr/wdata   downstream request, registered command
//   mem_addr_ok/data_ok/rdata     downstream accept, response, read data
//   dbg_state_o                   current arbiter state
//   dbg_starve_cnt_o              consecutive data grants while fetch waited
//   dbg_cancel_flag_o             pending fetch response will be dropped
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  // fetch side
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data side
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // downstream port
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  // debug visibility
  output arb_state_e          dbg_state_o,
  output logic [CNT_W-1:0]    dbg_starve_cnt_o,
  output logic                dbg_cancel_flag_o
);

  arb_state_e          state_q;
  logic [CNT_W-1:0]    starve_cnt_q;
  logic [CNT_W-1:0]    starve_cnt_d;
  logic                cancel_flag_q;
  logic                mem_wr_q;
  logic [1:0]          mem_size_q;
  logic [DATA_W/8-1:0] mem_wstrb_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                grant_data;
  logic                grant_inst;

  mem_bus_arbiter_arb_grant_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant_sel (
    .inst_req_i     (inst_req),
    .data_req_i     (data_req),
    .starve_cnt_i   (starve_cnt_q),
    .grant_data_o   (grant_data),
    .grant_inst_o   (grant_inst),
    .starve_cnt_d_o (starve_cnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      starve_cnt_q  <= '0;
      cancel_flag_q <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_size_q    <= '0;
      mem_wstrb_q   <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // Grant costs one cycle: the command is captured here and only
          // presented downstream from the *_ADDR state onwards.
          starve_cnt_q <= starve_cnt_d;
          if (grant_data) begin
            mem_wr_q    <= data_wr;
            mem_size_q  <= data_size;
            mem_wstrb_q <= data_wstrb;
            mem_addr_q  <= data_addr;
            mem_wdata_q <= data_wdata;
            state_q     <= ARB_D_ADDR;
          end else if (grant_inst) begin
            mem_wr_q    <= 1'b0;
            mem_size_q  <= SIZE_W;
            mem_wstrb_q <= '0;
            mem_addr_q  <= inst_addr;
            mem_wdata_q <= '0;
            state_q     <= ARB_I_ADDR;
          end
        end
        ARB_I_ADDR: begin
          if (inst_cancel) begin
            cancel_flag_q <= 1'b1;
          end
          if (mem_addr_ok) begin
            state_q <= ARB_I_DATA;
          end
        end
        ARB_I_DATA: begin
          // The response that consumes the cancel also clears it, even if a
          // new cancel arrives in the same cycle.
          if (mem_data_ok) begin
            cancel_flag_q <= 1'b0;
            state_q       <= ARB_IDLE;
          end else if (inst_cancel) begin
            cancel_flag_q <= 1'b1;
          end
        end
        ARB_D_ADDR: begin
          if (mem_addr_ok) begin
            state_q <= ARB_D_DATA;
          end
        end
        ARB_D_DATA: begin
          if (mem_data_ok) begin
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_req      = (state_q == ARB_I_ADDR) || (state_q == ARB_D_ADDR);
    mem_wr       = mem_wr_q;
    mem_size     = mem_size_q;
    mem_wstrb    = mem_wstrb_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    // Accepts and responses are only forwarded in the owning phase, so stray
    // downstream strobes never reach a requester.
    inst_addr_ok = (state_q == ARB_I_ADDR) && mem_addr_ok;
    data_addr_ok = (state_q == ARB_D_ADDR) && mem_addr_ok;
    inst_data_ok = (state_q == ARB_I_DATA) && mem_data_ok && !(cancel_flag_q || inst_cancel);
    data_data_ok = (state_q == ARB_D_DATA) && mem_data_ok;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  assign dbg_state_o       = state_q;
  assign dbg_starve_cnt_o  = starve_cnt_q;
  assign dbg_cancel_flag_o = cancel_flag_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Bench for mem_bus_arbiter: reset checks, a table of single/dual request
// vectors with a zero-wait memory, hand-written multi-cycle corner sequences
// (starvation, cancel, reset mid-transaction) and a randomized phase checked
// against a transaction-level reference model with a command scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int SM = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  arb_state_e  dbg_state;
  logic [2:0]  dbg_starve_cnt;
  logic        dbg_cancel_flag;

  mem_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SM)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_cancel       (inst_cancel),
    .inst_addr_ok      (inst_addr_ok),
    .inst_data_ok      (inst_data_ok),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_wstrb        (data_wstrb),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata),
    .dbg_state_o       (dbg_state),
    .dbg_starve_cnt_o  (dbg_starve_cnt),
    .dbg_cancel_flag_o (dbg_cancel_flag)
  );

  // ---------------- records ----------------
  // Packed downstream command: {wr, size, wstrb, addr, wdata}
  typedef logic [70:0] cmd_t;

  typedef struct {
    logic        inst_req;
    logic        data_req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] iaddr;
    logic [31:0] rdata;
    logic        exp_first_d;
    cmd_t        exp_cmd;
    logic [2:0]  exp_cnt;
  } vec_t;

  int   n_vec;
  int   n_err;
  cmd_t exp_q[$];

  function automatic cmd_t fetch_cmd(input logic [31:0] a);
    return {1'b0, SIZE_W, 4'h0, a, 32'h0};
  endfunction

  function automatic vec_t mk(input logic ir, input logic dr, input logic wr,
                              input logic [1:0] sz, input logic [3:0] ws,
                              input logic [31:0] da, input logic [31:0] wd,
                              input logic [31:0] ia, input logic [31:0] rd,
                              input logic fd, input logic [2:0] cnt);
    vec_t v;
    v.inst_req = ir; v.data_req = dr; v.wr = wr; v.size = sz; v.wstrb = ws;
    v.daddr = da; v.wdata = wd; v.iaddr = ia; v.rdata = rd;
    v.exp_first_d = fd;
    v.exp_cmd = fd ? {wr, sz, ws, da, wd} : fetch_cmd(ia);
    v.exp_cnt = cnt;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transaction against a zero-wait memory, starting in a grant cycle with
  // requests already driven. Returns the owner and the command seen downstream.
  task automatic zw_txn(input logic [31:0] rd, input logic keep_d,
                        output logic own_d, output cmd_t seen, output logic [2:0] cnt_seen);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("grant_mem_req", mem_req, 1'b0);
    chk("grant_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    next_cycle();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("addr_mem_req", mem_req, 1'b1);
    chk("addr_ok_onehot", int'(inst_addr_ok) + int'(data_addr_ok), 1);
    own_d    = data_addr_ok;
    seen     = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
    cnt_seen = dbg_starve_cnt;
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    if (own_d) begin
      if (!keep_d) data_req = 1'b0;
    end else begin
      inst_req = 1'b0;
    end
    @(negedge clk);
    chk("resp_mem_req", mem_req, 1'b0);
    chk("resp_inst_data_ok", inst_data_ok, !own_d);
    chk("resp_data_data_ok", data_data_ok, own_d);
    chk("resp_rdata", own_d ? data_rdata : inst_rdata, rd);
    next_cycle();
    mem_data_ok = 1'b0;
  endtask

  // ---------------- reference model state (random phase) ----------------
  logic m_busy, m_acc, m_own_d, m_cancel, drop_i, drop_d, exp_mreq;
  int   m_cnt;

  // ---------------- main sequence ----------------
  initial begin
    vec_t       vecs[7];
    vec_t       v;
    logic       own;
    cmd_t       seen;
    logic [2:0] cs;
    int         sc_exp[6];

    n_vec = 0; n_err = 0;
    rst = 1'b1;
    inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

    vecs[0] = mk(1, 0, 0, SIZE_W, 4'h0, 32'h0,   32'h0,        32'h1C00_0000, 32'h0280_0000, 0, 0);
    vecs[1] = mk(0, 1, 1, SIZE_W, 4'hF, 32'h100, 32'hDEAD_BEEF, 32'h0,        32'h0,         1, 0);
    vecs[2] = mk(1, 1, 1, SIZE_W, 4'hF, 32'h100, 32'hDEAD_BEEF, 32'h1C00_0004, 32'h1111_1111, 1, 1);
    vecs[3] = mk(0, 1, 0, SIZE_B, 4'h0, 32'h203, 32'h55AA_55AA, 32'h0,        32'hA5A5_A5A5, 1, 0);
    vecs[4] = mk(0, 1, 1, SIZE_H, 4'hC, 32'h402, 32'h1234_0000, 32'h0,        32'h0,         1, 0);
    vecs[5] = mk(1, 1, 0, SIZE_W, 4'h0, 32'h800, 32'h0,        32'h1C00_0008, 32'h7777_7777, 1, 1);
    vecs[6] = mk(1, 0, 0, SIZE_W, 4'h0, 32'h0,   32'h0,        32'h1C00_000C, 32'h0000_0013, 0, 0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dbg_state, ARB_IDLE);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'h0);
    chk("rst_mem_cmd", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, 71'h0);
    chk("rst_starve_cnt", dbg_starve_cnt, 3'd0);
    chk("rst_cancel_flag", dbg_cancel_flag, 1'b0);
    next_cycle();
    rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      inst_req = v.inst_req; inst_addr = v.iaddr;
      data_req = v.data_req; data_wr = v.wr; data_size = v.size; data_wstrb = v.wstrb;
      data_addr = v.daddr; data_wdata = v.wdata;
      zw_txn(v.rdata, 1'b0, own, seen, cs);
      chk($sformatf("vec%0d_owner", i), own, v.exp_first_d);
      chk($sformatf("vec%0d_cmd", i), seen, v.exp_cmd);
      chk($sformatf("vec%0d_starve_cnt", i), cs, v.exp_cnt);
      if (v.inst_req && v.data_req) begin
        // Fetch lost arbitration and is still held: it must follow directly.
        zw_txn(~v.rdata, 1'b0, own, seen, cs);
        chk($sformatf("vec%0d_second_owner", i), own, 1'b0);
        chk($sformatf("vec%0d_second_cmd", i), seen, fetch_cmd(v.iaddr));
        chk($sformatf("vec%0d_second_cnt", i), cs, 3'd0);
      end
    end

    // ---- starvation guard: data held continuously, fetch pending ----
    sc_exp = '{1, 2, 3, 4, 0, 0};
    inst_req = 1; inst_addr = 32'h1C00_0010;
    data_req = 1; data_wr = 0; data_size = SIZE_W; data_wstrb = 0; data_addr = 32'h300; data_wdata = 0;
    for (int k = 0; k < 6; k++) begin
      zw_txn($urandom, 1'b1, own, seen, cs);
      chk($sformatf("starve_owner%0d", k), own, (k != 4));
      chk($sformatf("starve_cnt%0d", k), cs, sc_exp[k]);
    end
    data_req = 0;
    next_cycle();

    // ---- cancel in I_DATA, response delayed ----
    inst_req = 1; inst_addr = 32'h1C00_0020;
    @(negedge clk);
    chk("cxl_grant_mem_req", mem_req, 1'b0);
    next_cycle();
    mem_addr_ok = 1;
    @(negedge clk);
    chk("cxl_inst_addr_ok", inst_addr_ok, 1'b1);
    next_cycle();
    mem_addr_ok = 0; inst_req = 0; inst_cancel = 1;
    @(negedge clk);
    chk("cxl_no_data_ok0", inst_data_ok, 1'b0);
    next_cycle();
    inst_cancel = 0;
    @(negedge clk);
    chk("cxl_flag_set", dbg_cancel_flag, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("cxl_wait_mem_req", mem_req, 1'b0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("cxl_swallowed", inst_data_ok, 1'b0);
    chk("cxl_no_data_side", data_data_ok, 1'b0);
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    chk("cxl_flag_cleared", dbg_cancel_flag, 1'b0);
    chk("cxl_back_idle", dbg_state, ARB_IDLE);
    next_cycle();
    inst_req = 1; inst_addr = 32'h1C00_0024;
    zw_txn(32'h0000_0073, 1'b0, own, seen, cs);
    chk("cxl_next_owner", own, 1'b0);
    chk("cxl_next_cmd", seen, fetch_cmd(32'h1C00_0024));

    // ---- cancel coinciding with the response ----
    inst_req = 1; inst_addr = 32'h1C00_0028;
    next_cycle();
    mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; inst_req = 0; inst_cancel = 1; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("cxl2_swallowed", inst_data_ok, 1'b0);
    next_cycle();
    inst_cancel = 0; mem_data_ok = 0;
    @(negedge clk);
    chk("cxl2_flag_clear", dbg_cancel_flag, 1'b0);
    chk("cxl2_idle", dbg_state, ARB_IDLE);
    next_cycle();

    // ---- reset during D_DATA ----
    data_req = 1; data_wr = 1; data_size = SIZE_W; data_wstrb = 4'hF; data_addr = 32'h500; data_wdata = 32'hA0A0_A0A0;
    next_cycle();
    mem_addr_ok = 1;
    @(negedge clk);
    chk("rstd_data_addr_ok", data_addr_ok, 1'b1);
    next_cycle();
    mem_addr_ok = 0; data_req = 0; rst = 1;
    @(negedge clk);
    chk("rstd_in_d_data", dbg_state, ARB_D_DATA);
    next_cycle();
    rst = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("rstd_idle", dbg_state, ARB_IDLE);
    chk("rstd_mem_req", mem_req, 1'b0);
    chk("rstd_late_data_ok", data_data_ok, 1'b0);
    chk("rstd_late_inst_ok", inst_data_ok, 1'b0);
    chk("rstd_mem_addr", mem_addr, 32'h0);
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    chk("rstd_still_idle", mem_req, 1'b0);
    next_cycle();

    // ---- randomized phase with reference model ----
    m_busy = 0; m_acc = 0; m_own_d = 0; m_cancel = 0; m_cnt = 0; drop_i = 0; drop_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (drop_i) inst_req = 0;
      if (drop_d) data_req = 0;
      drop_i = 0; drop_d = 0;
      if (!inst_req && $urandom_range(0, 3) == 0) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom_range(0, 15)); data_addr = $urandom; data_wdata = $urandom;
      end
      inst_cancel = ($urandom_range(0, 7) == 0);
      if (m_busy && !m_acc) mem_addr_ok = ($urandom_range(0, 1) == 0);
      else                  mem_addr_ok = ($urandom_range(0, 7) == 0);
      if (m_busy && m_acc)  mem_data_ok = ($urandom_range(0, 2) == 0);
      else                  mem_data_ok = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;

      @(negedge clk);
      exp_mreq = m_busy && !m_acc;
      chk("rnd_mem_req", mem_req, exp_mreq);
      chk("rnd_inst_addr_ok", inst_addr_ok, exp_mreq && !m_own_d && mem_addr_ok);
      chk("rnd_data_addr_ok", data_addr_ok, exp_mreq && m_own_d && mem_addr_ok);
      chk("rnd_inst_data_ok", inst_data_ok,
          m_busy && m_acc && !m_own_d && mem_data_ok && !(m_cancel || inst_cancel));
      chk("rnd_data_data_ok", data_data_ok, m_busy && m_acc && m_own_d && mem_data_ok);
      chk("rnd_inst_rdata", inst_rdata, mem_rdata);
      chk("rnd_data_rdata", data_rdata, mem_rdata);
      chk("rnd_starve_cnt", dbg_starve_cnt, m_cnt);
      chk("rnd_cancel_flag", dbg_cancel_flag, m_cancel);
      if (mem_req && mem_addr_ok) begin
        chk("rnd_sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0)
          chk("rnd_sb_cmd", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, exp_q.pop_front());
      end

      if (!m_busy) begin
        if (data_req && !(inst_req && m_cnt == SM)) begin
          m_busy = 1; m_own_d = 1;
          exp_q.push_back({data_wr, data_size, data_wstrb, data_addr, data_wdata});
          m_cnt = inst_req ? ((m_cnt + 1 > SM) ? SM : m_cnt + 1) : 0;
        end else if (inst_req) begin
          m_busy = 1; m_own_d = 0;
          exp_q.push_back(fetch_cmd(inst_addr));
          m_cnt = 0;
        end
      end else if (!m_acc) begin
        if (!m_own_d && inst_cancel) m_cancel = 1;
        if (mem_addr_ok) begin
          m_acc = 1;
          if (m_own_d) drop_d = 1; else drop_i = 1;
        end
      end else begin
        if (!m_own_d) begin
          if (mem_data_ok)      m_cancel = 0;
          else if (inst_cancel) m_cancel = 1;
        end
        if (mem_data_ok) begin
          m_busy = 0; m_acc = 0;
        end
      end
      next_cycle();
    end
    chk("rnd_sb_leftover", exp_q.size(), (m_busy && !m_acc) ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
